// File: rtl/neuron_mac.sv
// Fixed-point neuron pre-activation: streamed MAC against a sync-read weight memory, then bias, rescale, saturate.
// Build option: define NEURON_MAC_SAT_EN for saturating accumulation with a sticky ovf flag (otherwise wrap, ovf=0).
module neuron_mac #(
    parameter int DATAWIDTH   = 16,
    parameter int FRAC_BITS   = 8,
    parameter int NUM_WEIGHTS = 784,
    parameter int ACCWIDTH    = 40,
    parameter int SIG_INWIDTH = 6,
    parameter int SIG_SHIFT   = 16,
    localparam int AW = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATAWIDTH-1:0]   in_data,
    output logic [AW-1:0]          w_addr,
    input  logic [DATAWIDTH-1:0]   w_data,
    input  logic [DATAWIDTH-1:0]   bias,
    output logic                   out_valid,
    output logic [SIG_INWIDTH-1:0] sig_x,
    output logic                   ovf
);
    localparam int PW        = 2 * DATAWIDTH;
    localparam int SIG_MAX_I = 2 ** (SIG_INWIDTH - 1) - 1;

    typedef enum logic [1:0] {S_ACC, S_DRAIN, S_FINISH, S_OUT} state_t;
    state_t state;

    logic [AW-1:0]                count;
    logic                         v1, last1, v2, last2, done;
    logic signed [DATAWIDTH-1:0]  d1;
    logic signed [PW-1:0]         prod;
    logic signed [ACCWIDTH-1:0]   acc;
    logic signed [ACCWIDTH-1:0]   prod_acc, bias_acc, mac_next, fin_t, s_val;
    logic signed [ACCWIDTH-1:0]   lim_hi, lim_lo;
    logic [SIG_INWIDTH-1:0]       sig_next;
    logic                         accept, last_acc;

    assign accept   = in_valid && in_ready;
    assign last_acc = accept && (count == AW'(NUM_WEIGHTS - 1));
    assign w_addr   = count;

    assign prod_acc = {{(ACCWIDTH-PW){prod[PW-1]}}, prod};
    assign bias_acc = {{(ACCWIDTH-DATAWIDTH){bias[DATAWIDTH-1]}}, bias} <<< FRAC_BITS;

`ifdef NEURON_MAC_SAT_EN
    // One guard bit on each add; a guard/sign disagreement means the signed range was exceeded.
    logic signed [ACCWIDTH:0] sum_mac, sum_fin;
    logic                     ovf_mac, ovf_fin;
    logic signed [ACCWIDTH-1:0] acc_max, acc_min;

    assign acc_max = {1'b0, {(ACCWIDTH-1){1'b1}}};
    assign acc_min = {1'b1, {(ACCWIDTH-1){1'b0}}};
    assign sum_mac = {acc[ACCWIDTH-1], acc} + {prod_acc[ACCWIDTH-1], prod_acc};
    assign sum_fin = {acc[ACCWIDTH-1], acc} + {bias_acc[ACCWIDTH-1], bias_acc};
    assign ovf_mac = sum_mac[ACCWIDTH] != sum_mac[ACCWIDTH-1];
    assign ovf_fin = sum_fin[ACCWIDTH] != sum_fin[ACCWIDTH-1];
    assign mac_next = ovf_mac ? (sum_mac[ACCWIDTH] ? acc_min : acc_max) : sum_mac[ACCWIDTH-1:0];
    assign fin_t    = ovf_fin ? (sum_fin[ACCWIDTH] ? acc_min : acc_max) : sum_fin[ACCWIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if ((v2 && ovf_mac) || (state == S_FINISH && ovf_fin)) begin
            ovf <= 1'b1;
        end
    end
`else
    assign mac_next = acc + prod_acc;
    assign fin_t    = acc + bias_acc;
    assign ovf      = 1'b0;
`endif

    assign s_val  = fin_t >>> SIG_SHIFT;
    assign lim_hi = ACCWIDTH'(SIG_MAX_I);
    assign lim_lo = ACCWIDTH'(-SIG_MAX_I - 1);

    always_comb begin
        sig_next = s_val[SIG_INWIDTH-1:0];
        if (s_val > lim_hi)      sig_next = lim_hi[SIG_INWIDTH-1:0];
        else if (s_val < lim_lo) sig_next = lim_lo[SIG_INWIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_ACC;
            count     <= '0;
            in_ready  <= 1'b1;
            v1        <= 1'b0;
            last1     <= 1'b0;
            d1        <= '0;
            v2        <= 1'b0;
            last2     <= 1'b0;
            prod      <= '0;
            done      <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            sig_x     <= '0;
        end else begin
            // Pipeline: E1 registers the activation while the memory returns w_data, E2 multiplies, E3 accumulates.
            v1    <= accept;
            last1 <= last_acc;
            if (accept) d1 <= in_data;
            v2    <= v1;
            last2 <= v1 && last1;
            if (v1) prod <= d1 * $signed(w_data);
            if (v2 && last2) done <= 1'b1;
            out_valid <= 1'b0;

            if (state == S_OUT) acc <= '0;
            else if (v2)        acc <= mac_next;

            case (state)
                S_ACC: begin
                    if (last_acc) begin
                        in_ready <= 1'b0;
                        state    <= S_DRAIN;
                    end else if (accept) begin
                        count <= count + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (done) state <= S_FINISH;
                end
                S_FINISH: begin
                    sig_x     <= sig_next;
                    out_valid <= 1'b1;
                    done      <= 1'b0;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    count    <= '0;
                    in_ready <= 1'b1;
                    state    <= S_ACC;
                end
                default: state <= S_ACC;
            endcase
        end
    end
endmodule
